// File: rtl/linebuf_2_if.sv
// Row-in / window-out bus of the 4-row line buffer.
// The upstream producer drives rows; the buffer drives the window side.
interface linebuf_2_if #(
    parameter int COLS  = 20,
    parameter int PIX_W = 8
);
    logic [COLS*PIX_W-1:0]   row_i;
    logic                    row_valid_i;
    logic                    row_ready_o;
    logic [COLS*4*PIX_W-1:0] win_o;
    logic                    win_valid_o;
    logic                    frame_done_o;

    modport master (
        output row_i, row_valid_i,
        input  row_ready_o, win_o, win_valid_o, frame_done_o
    );

    modport slave (
        input  row_i, row_valid_i,
        output row_ready_o, win_o, win_valid_o, frame_done_o
    );
endinterface

// File: rtl/linebuf_2.sv
// 4-row sliding window buffer: fills 4 rows, holds each window for HOLD_CYC
// cycles, then slides down by 2 rows until the frame's last window.
module linebuf_2 #(
    parameter int COLS       = 20,
    parameter int PIX_W      = 8,
    parameter int FRAME_ROWS = 20,
    parameter int HOLD_CYC   = 18
) (
    input logic        clk,
    input logic        rst_n,
    linebuf_2_if.slave bus
);
    localparam int ROW_W    = COLS * PIX_W;
    localparam int WIN_LAST = FRAME_ROWS / 2 - 2;
    localparam int HC_W     = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int WI_W     = (WIN_LAST > 0) ? $clog2(WIN_LAST + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD_CYC - 1);
    localparam logic [WI_W-1:0] WIN_MAX  = WI_W'(WIN_LAST);

    typedef enum logic [1:0] {
        S_FILL,
        S_HOLD,
        S_REFILL
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      row_cnt, row_cnt_nxt;
    logic [HC_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [WI_W-1:0] win_idx, win_idx_nxt;
    logic            win_valid_q, win_valid_nxt;
    logic            frame_done_q, frame_done_nxt;
    logic            row_ready;
    logic            accept;
    logic [ROW_W-1:0] win_r [4];

    assign row_ready        = (state != S_HOLD);
    assign accept           = bus.row_valid_i && row_ready;
    assign bus.row_ready_o  = row_ready;
    assign bus.win_valid_o  = win_valid_q;
    assign bus.frame_done_o = frame_done_q;

    always_comb begin
        state_nxt      = state;
        row_cnt_nxt    = row_cnt;
        hold_cnt_nxt   = hold_cnt;
        win_idx_nxt    = win_idx;
        win_valid_nxt  = win_valid_q;
        frame_done_nxt = 1'b0;
        unique case (state)
            S_FILL, S_REFILL: begin
                if (accept) begin
                    // FILL needs 4 fresh rows, REFILL only 2 to slide the window
                    if ((state == S_FILL   && row_cnt == 2'd3) ||
                        (state == S_REFILL && row_cnt == 2'd1)) begin
                        state_nxt     = S_HOLD;
                        row_cnt_nxt   = '0;
                        hold_cnt_nxt  = '0;
                        win_valid_nxt = 1'b1;
                    end else begin
                        row_cnt_nxt = row_cnt + 2'd1;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_MAX) begin
                    win_valid_nxt = 1'b0;
                    if (win_idx < WIN_MAX) begin
                        state_nxt   = S_REFILL;
                        win_idx_nxt = win_idx + 1'b1;
                    end else begin
                        state_nxt      = S_FILL;
                        frame_done_nxt = 1'b1;
                        win_idx_nxt    = '0;
                        row_cnt_nxt    = '0;
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FILL;
            row_cnt      <= '0;
            hold_cnt     <= '0;
            win_idx      <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int unsigned r = 0; r < 4; r++) begin
                win_r[r] <= '0;
            end
        end else begin
            state        <= state_nxt;
            row_cnt      <= row_cnt_nxt;
            hold_cnt     <= hold_cnt_nxt;
            win_idx      <= win_idx_nxt;
            win_valid_q  <= win_valid_nxt;
            frame_done_q <= frame_done_nxt;
            if (accept) begin
                win_r[0] <= win_r[1];
                win_r[1] <= win_r[2];
                win_r[2] <= win_r[3];
                win_r[3] <= bus.row_i;
            end
        end
    end

    // Column-major window layout: the 4 rows of a column sit side by side.
    always_comb begin
        bus.win_o = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                bus.win_o[c*4*PIX_W + r*PIX_W +: PIX_W] = win_r[r][c*PIX_W +: PIX_W];
            end
        end
    end
endmodule

// File: tb/tb_linebuf_2.sv
// Randomized bench for linebuf_2 against a row-history reference model.
module tb_linebuf_2;
    localparam int COLS       = 20;
    localparam int PIX_W      = 8;
    localparam int FRAME_ROWS = 20;
    localparam int HOLD_CYC   = 18;
    localparam int ROW_W      = COLS * PIX_W;
    localparam int WW         = COLS * 4 * PIX_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    linebuf_2_if #(.COLS(COLS), .PIX_W(PIX_W)) lb_if ();

    linebuf_2 #(
        .COLS(COLS),
        .PIX_W(PIX_W),
        .FRAME_ROWS(FRAME_ROWS),
        .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(lb_if)
    );

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: rows accepted this frame, hold timer, last 4 rows seen.
    int               m_n    = 0;
    int               m_hold = 0;
    logic             m_fd   = 1'b0;
    logic [ROW_W-1:0] hist[$] = '{'0, '0, '0, '0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n    <= 0;
            m_hold <= 0;
            m_fd   <= 1'b0;
            hist   = '{'0, '0, '0, '0};
        end else if (m_hold > 0) begin
            m_hold <= m_hold - 1;
            m_fd   <= (m_hold == 1 && m_n == FRAME_ROWS);
            if (m_hold == 1 && m_n == FRAME_ROWS) m_n <= 0;
        end else begin
            m_fd <= 1'b0;
            if (lb_if.row_valid_i) begin
                hist.push_back(lb_if.row_i);
                void'(hist.pop_front());
                m_n <= m_n + 1;
                if (m_n + 1 >= 4 && (m_n + 1) % 2 == 0) m_hold <= HOLD_CYC;
            end
        end
    end

    function automatic logic [WW-1:0] model_win();
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < COLS; c++)
                w[c*4*PIX_W + r*PIX_W +: PIX_W] = hist[r][c*PIX_W +: PIX_W];
        return w;
    endfunction

    // Per-cycle comparison plus window/frame bookkeeping on observed outputs.
    int   win_rises = 0;
    int   win_base  = 0;
    int   fd_count  = 0;
    int   run       = 0;
    int   gap       = 0;
    logic prev_v    = 1'b0;
    logic seen_win  = 1'b0;

    always @(negedge clk) begin
        chk("ready", WW'(lb_if.row_ready_o), WW'(m_hold == 0));
        chk("win_valid", WW'(lb_if.win_valid_o), WW'(m_hold != 0));
        chk("frame_done", WW'(lb_if.frame_done_o), WW'(m_fd));
        chk("win", lb_if.win_o, model_win());
        if (!rst_n) begin
            prev_v   <= 1'b0;
            run      <= 0;
            gap      <= 0;
            seen_win <= 1'b0;
            win_base <= win_rises;
        end else begin
            if (lb_if.win_valid_o && !prev_v) begin
                win_rises <= win_rises + 1;
                if (seen_win) chk("win_gap_ge2", WW'(gap >= 2), WW'(1));
                seen_win <= 1'b1;
                run      <= 1;
            end else if (lb_if.win_valid_o) begin
                run <= run + 1;
            end
            if (!lb_if.win_valid_o && prev_v) begin
                chk("hold_len", WW'(run), WW'(HOLD_CYC));
                gap <= 1;
            end else if (!lb_if.win_valid_o) begin
                gap <= gap + 1;
            end
            if (lb_if.frame_done_o) begin
                chk("frame_wins", WW'(win_rises - win_base), WW'(FRAME_ROWS / 2 - 1));
                win_base <= win_rises;
                fd_count <= fd_count + 1;
            end
            prev_v <= lb_if.win_valid_o;
        end
    end

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*PIX_W +: PIX_W] = PIX_W'($urandom);
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] const_row(input int k);
        logic [ROW_W-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*PIX_W +: PIX_W] = PIX_W'(k);
        return v;
    endfunction

    function automatic logic [WW-1:0] ramp_win(input int base);
        logic [WW-1:0] w;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < 4; r++) w[c*4*PIX_W + r*PIX_W +: PIX_W] = PIX_W'(base + r);
        return w;
    endfunction

    // Junk is presented while the buffer is not ready; only r may be accepted.
    task automatic send_row(input logic [ROW_W-1:0] r, input int gap_cyc);
        int waited = 0;
        repeat (gap_cyc) begin
            @(negedge clk);
            lb_if.row_valid_i = 1'b0;
            lb_if.row_i       = rand_row();
        end
        forever begin
            @(negedge clk);
            lb_if.row_valid_i = 1'b1;
            if (lb_if.row_ready_o) begin
                lb_if.row_i = r;
                break;
            end
            lb_if.row_i = rand_row();
            waited++;
            if (waited > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout got=not_ready exp=ready_within_200");
                return;
            end
        end
    endtask

    task automatic send_frame(input int nrows, input int max_gap);
        for (int i = 0; i < nrows; i++) send_row(rand_row(), $urandom_range(0, max_gap));
    endtask

    initial begin
        lb_if.row_valid_i = 1'b0;
        lb_if.row_i       = '0;
        #1;
        chk("rst_ready", WW'(lb_if.row_ready_o), WW'(1));
        chk("rst_valid", WW'(lb_if.win_valid_o), WW'(0));
        chk("rst_fd", WW'(lb_if.frame_done_o), WW'(0));
        chk("rst_win", lb_if.win_o, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 1: directed ramp rows, row_valid held high throughout.
        for (int k = 0; k < 4; k++) send_row(const_row(k), 0);
        @(negedge clk);
        chk("fill_valid", WW'(lb_if.win_valid_o), WW'(1));
        chk("fill_win", lb_if.win_o, ramp_win(0));
        send_row(const_row(4), 0);
        send_row(const_row(5), 0);
        @(negedge clk);
        chk("refill_valid", WW'(lb_if.win_valid_o), WW'(1));
        chk("refill_win", lb_if.win_o, ramp_win(2));
        for (int k = 6; k < FRAME_ROWS; k++) send_row(const_row(k), 0);

        // Frame 2 back-to-back with random gaps, then a partial frame 3.
        send_frame(FRAME_ROWS, 3);
        send_frame(6, 1);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", WW'(lb_if.row_ready_o), WW'(1));
        chk("midrst_valid", WW'(lb_if.win_valid_o), WW'(0));
        chk("midrst_fd", WW'(lb_if.frame_done_o), WW'(0));
        chk("midrst_win", lb_if.win_o, '0);
        @(negedge clk);
        lb_if.row_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 4: fresh frame after reset, bursty input.
        send_frame(FRAME_ROWS, 4);
        @(negedge clk);
        lb_if.row_valid_i = 1'b0;
        for (int i = 0; i < HOLD_CYC + 20 && fd_count < 3; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("frames_done", WW'(fd_count), WW'(3));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
